// File: rtl/ucie_ctl_phy_link_train_seq.sv
// ucie_ctl_phy_link_train_seq
//
// Link-training sequencer for the UCIe controller PHY model. Sits upstream of
// the PHY FSM control block. A training run starts either from the CSR
// start-training bit or from a partner-die TRAIN_REQ. It then performs a
// sideband handshake (TRAIN_REQ / TRAIN_RSP) and a capability exchange
// (PARAM_REQ in both directions). It reports done or trainerror, plus the
// negotiated speed and link config, to the PHY FSM.
//
// Parameters
//   TIMEOUT_CYCLES  cycles to wait for each partner response
//   MAX_RETRY       TRAIN_REQ re-sends allowed after a response timeout
//
// Ports
//   i_clk            clock
//   i_rst            synchronous active-high reset
//   i_start          CSR start-training bit (level)
//   i_abort          return to IDLE from any state (pulse)
//   i_local_speed    local max speed mode
//   i_local_lnk_cfg  local max link config
//   i_sb_msg_in      partner sideband message, 0 = NOP
//   i_sb_param_in    partner {speed,lnk_cfg}, meaningful with PARAM_REQ
//   o_sb_msg_out     sideband message to partner, 1-cycle pulses
//   o_sb_param_out   local caps while PARAM_REQ is sent, else 0
//   o_clear_start    1-cycle pulse when i_start is accepted
//   o_busy           high while a training run is in progress
//   o_training_done  high in DONE
//   o_trainerror     high in ERROR
//   o_speedmode      negotiated speed, valid in DONE
//   o_lnk_cfg        negotiated link config, valid in DONE

module ucie_ctl_phy_link_train_seq #(
  parameter int TIMEOUT_CYCLES = 256,
  parameter int MAX_RETRY      = 3
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_start,
  input  logic       i_abort,
  input  logic [2:0] i_local_speed,
  input  logic [2:0] i_local_lnk_cfg,
  input  logic [3:0] i_sb_msg_in,
  input  logic [5:0] i_sb_param_in,
  output logic [3:0] o_sb_msg_out,
  output logic [5:0] o_sb_param_out,
  output logic       o_clear_start,
  output logic       o_busy,
  output logic       o_training_done,
  output logic       o_trainerror,
  output logic [2:0] o_speedmode,
  output logic [2:0] o_lnk_cfg
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int RW = $clog2(MAX_RETRY + 1);

  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] TIMER_MAX  = TW'(TIMEOUT_CYCLES);
  localparam logic [RW-1:0] RETRY_MAX  = RW'(MAX_RETRY);

  localparam logic [3:0] MSG_NOP       = 4'd0;
  localparam logic [3:0] MSG_TRAIN_REQ = 4'd1;
  localparam logic [3:0] MSG_TRAIN_RSP = 4'd2;
  localparam logic [3:0] MSG_PARAM_REQ = 4'd3;

  typedef enum logic [2:0] {
    IDLE,
    SEND_REQ,
    WAIT_RSP,
    RESPOND,
    PARAM,
    WAIT_PARAM,
    DONE,
    ERROR
  } state_t;

  state_t        state;
  logic [TW-1:0] timer;
  logic [RW-1:0] retry;
  logic          param_seen;
  logic [5:0]    remote_caps;

  // Remote caps as seen on the DONE decision: a PARAM_REQ arriving in the same
  // cycle as the WAIT_PARAM decision has not been latched yet, so use it directly.
  logic [5:0] eff_remote;
  logic [2:0] neg_speed;
  logic [2:0] neg_cfg;

  assign eff_remote = param_seen ? remote_caps : i_sb_param_in;
  assign neg_speed  = (i_local_speed   < eff_remote[5:3]) ? i_local_speed   : eff_remote[5:3];
  assign neg_cfg    = (i_local_lnk_cfg < eff_remote[2:0]) ? i_local_lnk_cfg : eff_remote[2:0];

  // Single sequencer process. Every output is registered and is set on the
  // transition into the state that owns it, so a message appears exactly in
  // the cycle after the state decision.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_abort) begin
      state           <= IDLE;
      timer           <= '0;
      retry           <= '0;
      param_seen      <= 1'b0;
      remote_caps     <= '0;
      o_sb_msg_out    <= MSG_NOP;
      o_sb_param_out  <= '0;
      o_clear_start   <= 1'b0;
      o_busy          <= 1'b0;
      o_training_done <= 1'b0;
      o_trainerror    <= 1'b0;
      o_speedmode     <= '0;
      o_lnk_cfg       <= '0;
    end else begin
      o_sb_msg_out   <= MSG_NOP;
      o_sb_param_out <= '0;
      o_clear_start  <= 1'b0;

      // Saturating timer; restarted explicitly by SEND_REQ and PARAM.
      if (timer != TIMER_MAX) begin
        timer <= timer + 1'b1;
      end

      // Partner caps are only accepted once the capability exchange is underway.
      if ((state == RESPOND || state == PARAM || state == WAIT_PARAM) &&
          i_sb_msg_in == MSG_PARAM_REQ) begin
        param_seen  <= 1'b1;
        remote_caps <= i_sb_param_in;
      end

      case (state)
        IDLE: begin
          if (i_sb_msg_in == MSG_TRAIN_REQ) begin
            state        <= RESPOND;
            o_sb_msg_out <= MSG_TRAIN_RSP;
            o_busy       <= 1'b1;
            param_seen   <= 1'b0;
          end else if (i_start) begin
            state         <= SEND_REQ;
            o_sb_msg_out  <= MSG_TRAIN_REQ;
            o_clear_start <= 1'b1;
            o_busy        <= 1'b1;
            param_seen    <= 1'b0;
          end
        end

        SEND_REQ: begin
          timer <= '0;
          state <= WAIT_RSP;
        end

        WAIT_RSP: begin
          if (i_sb_msg_in == MSG_TRAIN_RSP) begin
            state          <= PARAM;
            o_sb_msg_out   <= MSG_PARAM_REQ;
            o_sb_param_out <= {i_local_speed, i_local_lnk_cfg};
          end else if (i_sb_msg_in == MSG_TRAIN_REQ) begin
            // Both dies requested at once: answer the partner instead.
            state        <= RESPOND;
            o_sb_msg_out <= MSG_TRAIN_RSP;
          end else if (timer == TIMER_LAST) begin
            if (retry < RETRY_MAX) begin
              retry        <= retry + 1'b1;
              state        <= SEND_REQ;
              o_sb_msg_out <= MSG_TRAIN_REQ;
            end else begin
              state        <= ERROR;
              o_busy       <= 1'b0;
              o_trainerror <= 1'b1;
            end
          end
        end

        RESPOND: begin
          state          <= PARAM;
          o_sb_msg_out   <= MSG_PARAM_REQ;
          o_sb_param_out <= {i_local_speed, i_local_lnk_cfg};
        end

        PARAM: begin
          timer <= '0;
          state <= WAIT_PARAM;
        end

        WAIT_PARAM: begin
          if (param_seen || i_sb_msg_in == MSG_PARAM_REQ) begin
            state           <= DONE;
            retry           <= '0;
            o_busy          <= 1'b0;
            o_training_done <= 1'b1;
            o_speedmode     <= neg_speed;
            o_lnk_cfg       <= neg_cfg;
          end else if (timer == TIMER_LAST) begin
            state        <= ERROR;
            o_busy       <= 1'b0;
            o_trainerror <= 1'b1;
          end
        end

        DONE: begin
          // Retrain request: forget the previous partner caps.
          if (i_sb_msg_in == MSG_TRAIN_REQ) begin
            state           <= RESPOND;
            o_sb_msg_out    <= MSG_TRAIN_RSP;
            o_busy          <= 1'b1;
            o_training_done <= 1'b0;
            o_speedmode     <= '0;
            o_lnk_cfg       <= '0;
            param_seen      <= 1'b0;
          end
        end

        ERROR: begin
          state <= ERROR;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ucie_ctl_phy_link_train_seq.sv
// tb_ucie_ctl_phy_link_train_seq
//
// Directed bench for the link-training sequencer, built with a short timeout
// (8 cycles) so the retry and timeout paths are reached quickly. Inputs are
// driven 1 time unit after each rising edge, and outputs are sampled there.
// Each check compares a packed snapshot of all outputs against a hand-built
// expected snapshot.

module tb_ucie_ctl_phy_link_train_seq;

  logic       clk;
  logic       rst;
  logic       start;
  logic       abort;
  logic [2:0] local_speed;
  logic [2:0] local_lnk_cfg;
  logic [3:0] sb_msg_in;
  logic [5:0] sb_param_in;
  logic [3:0] sb_msg_out;
  logic [5:0] sb_param_out;
  logic       clear_start;
  logic       busy;
  logic       training_done;
  logic       trainerror;
  logic [2:0] speedmode;
  logic [2:0] lnk_cfg;

  int total;
  int bad;
  int pulse_cnt;
  int pulse_at[3];
  int err_at;

  ucie_ctl_phy_link_train_seq #(
    .TIMEOUT_CYCLES(8),
    .MAX_RETRY(3)
  ) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_start        (start),
    .i_abort        (abort),
    .i_local_speed  (local_speed),
    .i_local_lnk_cfg(local_lnk_cfg),
    .i_sb_msg_in    (sb_msg_in),
    .i_sb_param_in  (sb_param_in),
    .o_sb_msg_out   (sb_msg_out),
    .o_sb_param_out (sb_param_out),
    .o_clear_start  (clear_start),
    .o_busy         (busy),
    .o_training_done(training_done),
    .o_trainerror   (trainerror),
    .o_speedmode    (speedmode),
    .o_lnk_cfg      (lnk_cfg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Packed snapshot: {msg, param, clear, busy, done, err, speed, cfg}
  logic [19:0] obs;
  assign obs = {sb_msg_out, sb_param_out, clear_start, busy, training_done,
                trainerror, speedmode, lnk_cfg};

  function automatic logic [19:0] snap(input logic [3:0] msg, input logic [5:0] prm,
                                       input logic clr, input logic bsy, input logic dn,
                                       input logic er, input logic [2:0] spd,
                                       input logic [2:0] cfg);
    return {msg, prm, clr, bsy, dn, er, spd, cfg};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic st, input logic ab, input logic [3:0] msg,
                               input logic [5:0] prm);
    start       = st;
    abort       = ab;
    sb_msg_in   = msg;
    sb_param_in = prm;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] got,
                             input logic [31:0] want);
    total++;
    assert (got === want)
      else begin
        bad++;
        $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, got, want);
      end
  endtask

  initial begin
    total         = 0;
    bad           = 0;
    rst           = 1'b1;
    local_speed   = 3'd5;
    local_lnk_cfg = 3'd3;
    pulse_at      = '{0, 0, 0};
    applyStimulus(1'b0, 1'b0, 4'd0, 6'd0);

    // Reset state
    tick();
    tick();
    checkOutput("reset", {12'd0, obs}, {12'd0, snap(0, 0, 0, 0, 0, 0, 0, 0)});
    rst = 1'b0;

    // Test 1: locally started training, partner caps {3,4}
    applyStimulus(1'b1, 1'b0, 4'd0, 6'd0);
    tick();
    checkOutput("t1_send_req", {12'd0, obs}, {12'd0, snap(1, 0, 1, 1, 0, 0, 0, 0)});
    applyStimulus(1'b0, 1'b0, 4'd0, 6'd0);
    tick();
    tick();
    tick();
    tick();
    checkOutput("t1_wait_rsp", {12'd0, obs}, {12'd0, snap(0, 0, 0, 1, 0, 0, 0, 0)});
    applyStimulus(1'b0, 1'b0, 4'd2, 6'd0);
    tick();
    checkOutput("t1_param", {12'd0, obs}, {12'd0, snap(3, 6'h2B, 0, 1, 0, 0, 0, 0)});
    applyStimulus(1'b0, 1'b0, 4'd0, 6'd0);
    tick();
    checkOutput("t1_wait_param", {12'd0, obs}, {12'd0, snap(0, 0, 0, 1, 0, 0, 0, 0)});
    applyStimulus(1'b0, 1'b0, 4'd3, 6'h1C);
    tick();
    checkOutput("t1_done", {12'd0, obs}, {12'd0, snap(0, 0, 0, 0, 1, 0, 3, 3)});
    applyStimulus(1'b0, 1'b0, 4'd0, 6'd0);
    tick();
    tick();
    checkOutput("t1_done_hold", {12'd0, obs}, {12'd0, snap(0, 0, 0, 0, 1, 0, 3, 3)});

    // Test 2: silent partner, 4 requests 9 cycles apart, then trainerror
    applyStimulus(1'b0, 1'b1, 4'd0, 6'd0);
    tick();
    checkOutput("t2_abort_done", {12'd0, obs}, {12'd0, snap(0, 0, 0, 0, 0, 0, 0, 0)});
    applyStimulus(1'b1, 1'b0, 4'd0, 6'd0);
    tick();
    checkOutput("t2_first_req", {12'd0, obs}, {12'd0, snap(1, 0, 1, 1, 0, 0, 0, 0)});
    applyStimulus(1'b0, 1'b0, 4'd0, 6'd0);
    pulse_cnt = 0;
    err_at    = -1;
    for (int c = 1; c <= 40; c++) begin
      tick();
      if (sb_msg_out == 4'd1) begin
        if (pulse_cnt < 3) pulse_at[pulse_cnt] = c;
        pulse_cnt++;
      end
      if (trainerror && err_at < 0) err_at = c;
    end
    checkOutput("t2_retry_count", pulse_cnt, 3);
    checkOutput("t2_retry1_at", pulse_at[0], 9);
    checkOutput("t2_retry2_at", pulse_at[1], 18);
    checkOutput("t2_retry3_at", pulse_at[2], 27);
    checkOutput("t2_error_at", err_at, 36);
    checkOutput("t2_error", {12'd0, obs}, {12'd0, snap(0, 0, 0, 0, 0, 1, 0, 0)});
    applyStimulus(1'b1, 1'b0, 4'd0, 6'd0);
    tick();
    checkOutput("t2_start_ignored", {12'd0, obs}, {12'd0, snap(0, 0, 0, 0, 0, 1, 0, 0)});
    applyStimulus(1'b0, 1'b1, 4'd0, 6'd0);
    tick();
    checkOutput("t2_abort_error", {12'd0, obs}, {12'd0, snap(0, 0, 0, 0, 0, 0, 0, 0)});

    // Test 3: start and partner request together; partner wins, start not cleared
    applyStimulus(1'b1, 1'b0, 4'd1, 6'd0);
    tick();
    checkOutput("t3_respond", {12'd0, obs}, {12'd0, snap(2, 0, 0, 1, 0, 0, 0, 0)});
    applyStimulus(1'b0, 1'b0, 4'd0, 6'd0);
    tick();
    checkOutput("t3_param", {12'd0, obs}, {12'd0, snap(3, 6'h2B, 0, 1, 0, 0, 0, 0)});
    tick();
    applyStimulus(1'b0, 1'b0, 4'd3, 6'h39);
    tick();
    checkOutput("t3_done", {12'd0, obs}, {12'd0, snap(0, 0, 0, 0, 1, 0, 5, 1)});

    // Test 4: crossed requests, partner caps {2,6} arriving in the PARAM cycle
    applyStimulus(1'b0, 1'b1, 4'd0, 6'd0);
    tick();
    applyStimulus(1'b1, 1'b0, 4'd0, 6'd0);
    tick();
    applyStimulus(1'b0, 1'b0, 4'd0, 6'd0);
    tick();
    applyStimulus(1'b0, 1'b0, 4'd1, 6'd0);
    tick();
    checkOutput("t4_crossed_rsp", {12'd0, obs}, {12'd0, snap(2, 0, 0, 1, 0, 0, 0, 0)});
    applyStimulus(1'b0, 1'b0, 4'd0, 6'd0);
    tick();
    checkOutput("t4_param", {12'd0, obs}, {12'd0, snap(3, 6'h2B, 0, 1, 0, 0, 0, 0)});
    applyStimulus(1'b0, 1'b0, 4'd3, 6'h16);
    tick();
    checkOutput("t4_wait_param", {12'd0, obs}, {12'd0, snap(0, 0, 0, 1, 0, 0, 0, 0)});
    applyStimulus(1'b0, 1'b0, 4'd0, 6'd0);
    tick();
    checkOutput("t4_done", {12'd0, obs}, {12'd0, snap(0, 0, 0, 0, 1, 0, 2, 3)});

    // Test 5: retrain from DONE with new partner caps {4,2}
    applyStimulus(1'b0, 1'b0, 4'd1, 6'd0);
    tick();
    checkOutput("t5_retrain_rsp", {12'd0, obs}, {12'd0, snap(2, 0, 0, 1, 0, 0, 0, 0)});
    applyStimulus(1'b0, 1'b0, 4'd0, 6'd0);
    tick();
    checkOutput("t5_param", {12'd0, obs}, {12'd0, snap(3, 6'h2B, 0, 1, 0, 0, 0, 0)});
    tick();
    tick();
    checkOutput("t5_wait_fresh", {12'd0, obs}, {12'd0, snap(0, 0, 0, 1, 0, 0, 0, 0)});
    applyStimulus(1'b0, 1'b0, 4'd3, 6'h22);
    tick();
    checkOutput("t5_done", {12'd0, obs}, {12'd0, snap(0, 0, 0, 0, 1, 0, 4, 2)});

    // WAIT_PARAM timeout goes straight to ERROR after exactly 8 cycles
    applyStimulus(1'b0, 1'b1, 4'd0, 6'd0);
    tick();
    applyStimulus(1'b1, 1'b0, 4'd0, 6'd0);
    tick();
    applyStimulus(1'b0, 1'b0, 4'd0, 6'd0);
    tick();
    applyStimulus(1'b0, 1'b0, 4'd2, 6'd0);
    tick();
    applyStimulus(1'b0, 1'b0, 4'd0, 6'd0);
    tick();
    for (int c = 0; c < 7; c++) tick();
    checkOutput("tp_before_timeout", {12'd0, obs}, {12'd0, snap(0, 0, 0, 1, 0, 0, 0, 0)});
    tick();
    checkOutput("tp_timeout", {12'd0, obs}, {12'd0, snap(0, 0, 0, 0, 0, 1, 0, 0)});

    // Test 6: reset in WAIT_PARAM, late partner PARAM_REQ is ignored
    applyStimulus(1'b0, 1'b1, 4'd0, 6'd0);
    tick();
    applyStimulus(1'b1, 1'b0, 4'd0, 6'd0);
    tick();
    applyStimulus(1'b0, 1'b0, 4'd0, 6'd0);
    tick();
    applyStimulus(1'b0, 1'b0, 4'd2, 6'd0);
    tick();
    applyStimulus(1'b0, 1'b0, 4'd0, 6'd0);
    tick();
    rst = 1'b1;
    tick();
    checkOutput("t6_reset", {12'd0, obs}, {12'd0, snap(0, 0, 0, 0, 0, 0, 0, 0)});
    rst = 1'b0;
    applyStimulus(1'b0, 1'b0, 4'd3, 6'h3F);
    tick();
    checkOutput("t6_late_param", {12'd0, obs}, {12'd0, snap(0, 0, 0, 0, 0, 0, 0, 0)});
    applyStimulus(1'b0, 1'b0, 4'd0, 6'd0);
    tick();
    tick();
    checkOutput("t6_idle", {12'd0, obs}, {12'd0, snap(0, 0, 0, 0, 0, 0, 0, 0)});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
